// File: rtl/digit_serial_subtractor.sv
// rtl/digit_serial_subtractor.sv - digit-serial unsigned subtractor, diff = a - b - bin
//
// Computes diff = a - b - bin (mod 2^WIDTH) DIGIT bits per clock, least
// significant digit first. One operation is in flight at a time, with a
// valid/ready handshake on both sides. Latency is N = WIDTH/DIGIT edges from
// the accepting edge to out_valid.
//
// Optional feature macro: SUB_OVERFLOW_EN (adds the signed-overflow output ovf).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands presented
//   in_ready   block can accept operands (high in IDLE)
//   a, b       minuend / subtrahend, unsigned, WIDTH bits
//   bin        borrow-in
//   out_valid  result held and valid (high in DONE)
//   out_ready  consumer accepts result
//   diff       a - b - bin, mod 2^WIDTH
//   bout       borrow-out, 1 iff a < b + bin
//   ovf        (SUB_OVERFLOW_EN only) signed two's-complement overflow

module digit_serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("digit_serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             brw;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

`ifdef SUB_OVERFLOW_EN
    // Operand sign bits are shifted out of a_sh/b_sh during RUN, so they are
    // kept separately for the overflow decision at the DONE transition.
    logic a_msb;
    logic b_msb;
    logic ovf_r;
`endif

    // Ripple-borrow subtract of the low digit of the operand shift registers.
    logic [DIGIT-1:0] dig;
    logic             dig_bout;

    always_comb begin
        logic br;
        dig = '0;
        br  = brw;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i] = a_sh[i] ^ b_sh[i] ^ br;
            br     = (~a_sh[i] & b_sh[i]) | (~a_sh[i] & br) | (b_sh[i] & br);
        end
        dig_bout = br;
    end

    // New digit enters diff from the MSB side; after N shifts the first digit
    // computed sits at the LSB. The concatenation avoids a zero-width slice
    // when DIGIT == WIDTH.
    logic [WIDTH+DIGIT-1:0] diff_cat;
    logic [WIDTH-1:0]       diff_next;

    always_comb begin
        diff_cat  = {dig, diff_r};
        diff_next = diff_cat[WIDTH+DIGIT-1:DIGIT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            brw    <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        brw    <= bin;
                        cnt    <= '0;
                        diff_r <= '0;
                        bout_r <= 1'b0;
`ifdef SUB_OVERFLOW_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        ovf_r  <= 1'b0;
`endif
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff_r <= diff_next;
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    brw    <= dig_bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bout_r <= dig_bout;
`ifdef SUB_OVERFLOW_EN
                        // dig[DIGIT-1] is the final diff MSB on this edge.
                        ovf_r  <= (a_msb != b_msb) && (dig[DIGIT-1] != a_msb);
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_r;
    assign bout      = bout_r;
`ifdef SUB_OVERFLOW_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// tb/tb_digit_serial_subtractor.sv - scoreboard bench for digit_serial_subtractor

module tb_digit_serial_subtractor;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    digit_serial_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   rdy_force = 1'b1;
    bit   rdy_val   = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input int acc);
        exp_t e;
        int   r;
        int   s;
        r     = int'(x) - int'(y) - int'(c);
        e.d   = W'(r & ((1 << W) - 1));
        e.bo  = (r < 0);
        s     = int'($signed(x)) - int'($signed(y)) - int'(c);
        e.ov  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
        e.acc = acc;
        return e;
    endfunction

    // Consumer: out_ready changes just after the rising edge, stable at negedge.
    always @(posedge clk) begin
        #1;
        out_ready = rdy_force ? rdy_val : ($urandom_range(0, 1) == 1);
    end

    // Monitor / scoreboard checker.
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 with no operation pending (cycle %0d)", cyc);
                end else begin
                    if (!prev_v) chk("latency", cyc, sb[0].acc + N);
                    chk("diff", diff, sb[0].d);
                    chk("bout", bout, sb[0].bo);
`ifdef SUB_OVERFLOW_EN
                    chk("ovf", ovf, sb[0].ov);
`endif
                    chk("in_ready_in_done", in_ready, 0);
                    if (out_ready) void'(sb.pop_front());
                end
            end else if (prev_v) begin
                chk("in_ready_after_handshake", in_ready, 1);
            end
            prev_v = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            timeout_fail("send_wait_in_ready");
            return;
        end
        a        = x;
        b        = y;
        bin      = c;
        in_valid = 1'b1;
        sb.push_back(model(x, y, c, cyc + 1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) timeout_fail("drain");
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_diff", diff, 0);
        chk("reset_bout", bout, 0);
`ifdef SUB_OVERFLOW_EN
        chk("reset_ovf", ovf, 0);
`endif
        rst_n = 1'b1;

        // Directed cases
        send(8'h5A, 8'h3C, 1'b0); drain();
        send(8'h00, 8'h01, 1'b0); drain();
        send(8'h00, 8'hFF, 1'b1); drain();
        send(8'h10, 8'h0F, 1'b1); drain();
        send(8'h77, 8'h77, 1'b0); drain();
        send(8'hFF, 8'h00, 1'b0); drain();
        send(8'h80, 8'h01, 1'b0); drain();
        send(8'h7F, 8'h01, 1'b0); drain();

        // Backpressure: hold DONE, offer new operands, they must not be taken
        rdy_val = 1'b0;
        send(8'hC3, 8'h5D, 1'b1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) timeout_fail("bp_wait_out_valid");
        for (int i = 0; i < 5; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            bin      = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        rdy_val  = 1'b1;
        drain();
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);

        // Mid-operation reset two edges after accept
        send(8'h55, 8'h22, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_diff", diff, 0);
        chk("rst_mid_bout", bout, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h03, 8'h01, 1'b0); drain();

        // Randomized operands with random consumer backpressure
        rdy_force = 1'b0;
        for (int i = 0; i < 40; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
        rdy_force = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
